// File: rtl/polyphony_voice_allocator.sv
// Polyphonic voice allocator: assigns note-on requests to voice slots, ages them on beats,
// and gathers per-voice samples into frames for the mixer. Optional macro: VOICE_STEAL_EN.
module polyphony_voice_allocator #(
  parameter int NUM_NOTES = 3,
  parameter int DUR_W     = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    note_on_valid,
  input  logic [5:0]              note_on,
  input  logic [DUR_W-1:0]        note_duration,
  output logic                    note_on_ready,
  input  logic                    beat,
  input  logic                    sample_tick,
  output logic [NUM_NOTES-1:0]    voice_load,
  output logic [5:0]              voice_note,
  output logic [NUM_NOTES-1:0]    voice_active,
  input  logic [NUM_NOTES-1:0]    voice_sample_ready,
  input  logic [NUM_NOTES*16-1:0] voice_samples,
  output logic                    samples_ready,
  output logic [NUM_NOTES*16-1:0] samples,
  output logic [7:0]              multiplier,
  output logic [3:0]              active_count
);

  localparam int IDX_W = $clog2(NUM_NOTES);
`ifdef VOICE_STEAL_EN
  localparam bit STEAL = 1'b1;
`else
  localparam bit STEAL = 1'b0;
`endif

  logic [DUR_W-1:0]        dur_q   [NUM_NOTES];
  logic [15:0]             lat_q   [NUM_NOTES];
  logic [NUM_NOTES-1:0]    collect_q;

  logic [NUM_NOTES-1:0]    expire;
  logic [NUM_NOTES-1:0]    load_vec;
  logic [NUM_NOTES-1:0]    smp_hit;
  logic [NUM_NOTES-1:0]    coll_smp;
  logic [NUM_NOTES-1:0]    active_nxt;
  logic [NUM_NOTES*16-1:0] frame_nxt;
  logic [IDX_W-1:0]        free_idx;
  logic [IDX_W-1:0]        steal_idx;
  logic [DUR_W-1:0]        best_dur;
  logic                    free_found;
  logic                    do_load;
  logic                    emit_voice;
  logic                    emit_zero;
  logic [3:0]              k;

  function automatic logic [7:0] mult_code(input logic [3:0] n);
    case (n)
      4'd2:    mult_code = 8'd128;
      4'd3:    mult_code = 8'd171;
      4'd4:    mult_code = 8'd192;
      4'd5:    mult_code = 8'd205;
      4'd6:    mult_code = 8'd213;
      4'd7:    mult_code = 8'd219;
      4'd8:    mult_code = 8'd224;
      default: mult_code = 8'd0;
    endcase
  endfunction

  always_comb begin
    expire     = '0;
    free_found = 1'b0;
    free_idx   = '0;
    steal_idx  = '0;
    best_dur   = dur_q[0];
    smp_hit    = voice_sample_ready & voice_active;
    k          = '0;
    frame_nxt  = '0;
    for (int i = 0; i < NUM_NOTES; i++) begin
      if (voice_active[i] && beat && dur_q[i] == DUR_W'(1)) expire[i] = 1'b1;
      if (!voice_active[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (i > 0 && dur_q[i] < best_dur) begin
        best_dur  = dur_q[i];
        steal_idx = IDX_W'(i);
      end
      k = k + 4'(voice_active[i]);
      if (voice_active[i])
        frame_nxt[i*16 +: 16] = smp_hit[i] ? voice_samples[i*16 +: 16] : lat_q[i];
    end
    // Allocation looks at pre-expiry occupancy; a slot freed this cycle is usable next cycle.
    do_load    = note_on_valid && note_on_ready && (note_duration != '0) && (free_found || STEAL);
    load_vec   = '0;
    if (do_load) load_vec = NUM_NOTES'(1) << (free_found ? free_idx : steal_idx);
    coll_smp   = collect_q | smp_hit;
    emit_voice = !samples_ready && (voice_active != '0) && (&(coll_smp | ~voice_active));
    emit_zero  = !samples_ready && (voice_active == '0) && sample_tick;
    active_nxt = (voice_active & ~expire) | load_vec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      note_on_ready <= 1'b0;
      voice_load    <= '0;
      voice_note    <= '0;
      voice_active  <= '0;
      collect_q     <= '0;
      samples_ready <= 1'b0;
      samples       <= '0;
      multiplier    <= '0;
      active_count  <= '0;
      for (int i = 0; i < NUM_NOTES; i++) begin
        dur_q[i] <= '0;
        lat_q[i] <= '0;
      end
    end else begin
      voice_active  <= active_nxt;
      note_on_ready <= STEAL ? 1'b1 : ~&active_nxt;
      voice_load    <= load_vec;
      if (do_load) voice_note <= note_on;
      for (int i = 0; i < NUM_NOTES; i++) begin
        if (load_vec[i])                  dur_q[i] <= note_duration;
        else if (voice_active[i] && beat) dur_q[i] <= dur_q[i] - DUR_W'(1);
        if (smp_hit[i]) lat_q[i] <= voice_samples[i*16 +: 16];
      end
      samples_ready <= emit_voice || emit_zero;
      if (emit_voice) begin
        samples      <= frame_nxt;
        multiplier   <= mult_code(k);
        active_count <= k;
      end else if (emit_zero) begin
        samples      <= '0;
        multiplier   <= '0;
        active_count <= '0;
      end
      // Expired, freshly loaded and stolen voices all restart their frame contribution.
      collect_q <= emit_voice ? '0 : (coll_smp & active_nxt & ~load_vec);
    end
  end

endmodule

// File: tb/tb_polyphony_voice_allocator.sv
// Randomized + directed bench for polyphony_voice_allocator against a voice-list reference model.
module tb_polyphony_voice_allocator;
  localparam int N  = 3;
  localparam int DW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          note_on_valid = 1'b0;
  logic [5:0]    note_on = '0;
  logic [DW-1:0] note_duration = '0;
  logic          note_on_ready;
  logic          beat = 1'b0;
  logic          sample_tick = 1'b0;
  logic [N-1:0]  voice_load;
  logic [5:0]    voice_note;
  logic [N-1:0]  voice_active;
  logic [N-1:0]  voice_sample_ready = '0;
  logic [N*16-1:0] voice_samples = '0;
  logic          samples_ready;
  logic [N*16-1:0] samples;
  logic [7:0]    multiplier;
  logic [3:0]    active_count;

  polyphony_voice_allocator #(.NUM_NOTES(N), .DUR_W(DW)) dut (
    .clk(clk), .reset(reset), .note_on_valid(note_on_valid), .note_on(note_on),
    .note_duration(note_duration), .note_on_ready(note_on_ready), .beat(beat),
    .sample_tick(sample_tick), .voice_load(voice_load), .voice_note(voice_note),
    .voice_active(voice_active), .voice_sample_ready(voice_sample_ready),
    .voice_samples(voice_samples), .samples_ready(samples_ready), .samples(samples),
    .multiplier(multiplier), .active_count(active_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // Reference model: voice table plus the last emitted frame.
  bit          m_act  [N];
  int          m_dur  [N];
  bit          m_have [N];
  logic [15:0] m_lat  [N];
  logic [15:0] m_frame[N];
  bit          m_ready, m_sr;
  int          m_load, m_note, m_mult, m_cnt;

  function automatic int gain(input int n);
    if (n < 2) return 0;
    return (512 * (n - 1) + n) / (2 * n);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic model_step();
    bit pre[N];
    int n_pre, victim, best;
    bit all_in, emit;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        m_act[i] = 0; m_dur[i] = 0; m_have[i] = 0; m_lat[i] = '0; m_frame[i] = '0;
      end
      m_ready = 0; m_sr = 0; m_load = 0; m_note = 0; m_mult = 0; m_cnt = 0;
      return;
    end
    n_pre = 0;
    for (int i = 0; i < N; i++) begin pre[i] = m_act[i]; n_pre += m_act[i]; end
    victim = -1;
    if (note_on_valid && m_ready && note_duration != 0) begin
      for (int i = 0; i < N; i++) if (!pre[i]) begin victim = i; break; end
`ifdef VOICE_STEAL_EN
      if (victim < 0) begin
        best = 1 << 30;
        for (int i = 0; i < N; i++) if (m_dur[i] < best) begin best = m_dur[i]; victim = i; end
      end
`endif
    end
    for (int i = 0; i < N; i++)
      if (pre[i] && voice_sample_ready[i]) begin
        m_lat[i] = voice_samples[i*16 +: 16]; m_have[i] = 1;
      end
    emit = 0;
    if (!m_sr) begin
      if (n_pre > 0) begin
        all_in = 1;
        for (int i = 0; i < N; i++) if (pre[i] && !m_have[i]) all_in = 0;
        if (all_in) begin
          for (int i = 0; i < N; i++) begin
            m_frame[i] = pre[i] ? m_lat[i] : 16'd0;
            m_have[i] = 0;
          end
          m_cnt = n_pre; m_mult = gain(n_pre); emit = 1;
        end
      end else if (sample_tick) begin
        for (int i = 0; i < N; i++) m_frame[i] = '0;
        m_cnt = 0; m_mult = 0; emit = 1;
      end
    end
    m_sr = emit;
    for (int i = 0; i < N; i++)
      if (pre[i] && beat) begin
        m_dur[i]--;
        if (m_dur[i] == 0) begin m_act[i] = 0; m_have[i] = 0; end
      end
    m_load = 0;
    if (victim >= 0) begin
      m_act[victim] = 1; m_dur[victim] = note_duration; m_have[victim] = 0;
      m_load = 1 << victim; m_note = note_on;
    end
`ifdef VOICE_STEAL_EN
    m_ready = 1;
`else
    m_ready = 0;
    for (int i = 0; i < N; i++) if (!m_act[i]) m_ready = 1;
`endif
  endtask

  function automatic logic [N*16-1:0] model_frame();
    logic [N*16-1:0] v;
    for (int i = 0; i < N; i++) v[i*16 +: 16] = m_frame[i];
    return v;
  endfunction

  function automatic logic [N-1:0] model_active();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_act[i];
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      chk("note_on_ready", note_on_ready, m_ready);
      chk("voice_load", voice_load, m_load[N-1:0]);
      chk("voice_note", voice_note, m_note[5:0]);
      chk("voice_active", voice_active, model_active());
      chk("samples_ready", samples_ready, m_sr);
      chk("samples", samples, model_frame());
      chk("multiplier", multiplier, m_mult[7:0]);
      chk("active_count", active_count, m_cnt[3:0]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    note_on_valid = 0; beat = 0; sample_tick = 0; voice_sample_ready = '0;
  endtask

  task automatic do_reset();
    idle(); reset = 1; cyc(); cyc(); reset = 0; cyc();
  endtask

  task automatic req(input int note, input int dur);
    note_on_valid = 1; note_on = 6'(note); note_duration = DW'(dur); cyc(); note_on_valid = 0;
  endtask

  task automatic sample(input int v, input int s);
    voice_sample_ready = N'(1) << v; voice_samples[v*16 +: 16] = 16'(s); cyc();
    voice_sample_ready = '0;
  endtask

  initial begin
    idle();
    reset = 1; cyc(); cyc();
    chk_on = 1;
    chk("rst_active", voice_active, 3'b000);
    chk("rst_ready", note_on_ready, 1'b0);
    chk("rst_mult", multiplier, 8'd0);
    chk("rst_sr", samples_ready, 1'b0);
    reset = 0; cyc();
    chk("ready_after_rst", note_on_ready, 1'b1);

    // Single note, three beats
    req(40, 3);
    chk("t1_load", voice_load, 3'b001);
    chk("t1_note", voice_note, 6'd40);
    chk("t1_active", voice_active, 3'b001);
    for (int b = 0; b < 3; b++) begin
      beat = 1; cyc(); beat = 0;
      if (b == 1) chk("t1_still_active", voice_active, 3'b001);
      cyc();
    end
    chk("t1_expired", voice_active, 3'b000);

    // Three voices, samples arrive in separate cycles
    req(10, 20); req(11, 20); req(12, 20);
    chk("t2_full", voice_active, 3'b111);
    sample(0, 12000); cyc();
    sample(1, 25000);
    chk("t2_no_strobe", samples_ready, 1'b0);
    sample(2, 45000);
    chk("t2_strobe", samples_ready, 1'b1);
    chk("t2_samples", samples, {16'd45000, 16'd25000, 16'd12000});
    chk("t2_mult", multiplier, 8'd171);
    chk("t2_count", active_count, 4'd3);
    cyc();
    chk("t2_one_shot", samples_ready, 1'b0);

    // Reset during a partial frame
    sample(0, 777);
    reset = 1; cyc();
    chk("t6_sr", samples_ready, 1'b0);
    chk("t6_samples", samples, '0);
    chk("t6_active", voice_active, 3'b000);
    chk("t6_count", active_count, 4'd0);
    reset = 0; cyc();

    // Idle frame on sample_tick
    sample_tick = 1; cyc(); sample_tick = 0;
    chk("t4_sr", samples_ready, 1'b1);
    chk("t4_samples", samples, '0);
    chk("t4_mult", multiplier, 8'd0);

    // Voice 1 expires while only voice 0 has reported
    do_reset();
    req(20, 10); req(21, 1);
    sample(0, 16'h1234); cyc();
    chk("t3_no_strobe", samples_ready, 1'b0);
    beat = 1; cyc(); beat = 0;
    chk("t3_expired", voice_active, 3'b001);
    cyc();
    chk("t3_strobe", samples_ready, 1'b1);
    chk("t3_samples", samples, {16'd0, 16'd0, 16'h1234});
    chk("t3_mult", multiplier, 8'd0);
    chk("t3_count", active_count, 4'd1);

    // Zero-duration request is consumed without allocation
    cyc();
    req(33, 0);
    chk("t7_load", voice_load, 3'b000);
    chk("t7_active", voice_active, 3'b001);

    // Full pool, new request
    do_reset();
    req(1, 5); req(2, 2); req(3, 2);
    note_on_valid = 1; note_on = 6'd9; note_duration = DW'(4);
`ifdef VOICE_STEAL_EN
    cyc(); note_on_valid = 0;
    chk("t5_steal_load", voice_load, 3'b010);
    chk("t5_steal_note", voice_note, 6'd9);
`else
    chk("t5_stall_ready", note_on_ready, 1'b0);
    cyc();
    chk("t5_stall_load", voice_load, 3'b000);
    beat = 1; cyc(); cyc(); beat = 0;
    chk("t5_freed_ready", note_on_ready, 1'b1);
    cyc(); note_on_valid = 0;
    chk("t5_late_load", voice_load, 3'b010);
`endif

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      reset              = ($urandom_range(0, 299) == 0);
      note_on_valid      = ($urandom_range(0, 9) < 3);
      note_on            = 6'($urandom);
      note_duration      = ($urandom_range(0, 7) == 0) ? DW'(0) : DW'($urandom_range(1, 6));
      beat               = ($urandom_range(0, 9) == 0);
      sample_tick        = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < N; i++) voice_sample_ready[i] = ($urandom_range(0, 3) == 0);
      voice_samples      = {16'($urandom), 16'($urandom), 16'($urandom)};
      cyc();
    end
    idle(); reset = 0; cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/polyphony_voice_allocator.md
Name: polyphony_voice_allocator

Overview:
Upstream neighbour of polyphony_mixer. Accepts note-on requests and assigns each to a free voice slot. Counts voice durations down on beat ticks. Gathers one 16-bit sample per active voice into a frame, then hands the frame and a voice-count multiplier to the mixer using its samples_ready/samples/multiplier interface.

Parameters:
NUM_NOTES, 3, number of voice slots (2..8); sample bus width is NUM_NOTES*16
DUR_W, 6, width of the note duration counter, in beats

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
note_on_valid  in  1  note-on request valid
note_on  in  6  note number
note_duration  in  DUR_W  length in beats; 0 = discard request
note_on_ready  out  1  request accepted this cycle when valid & ready
beat  in  1  1-cycle strobe; decrements all active durations
sample_tick  in  1  1-cycle output-rate strobe, used only when no voice is active
voice_load  out  NUM_NOTES  one-hot 1-cycle strobe: (re)start voice i
voice_note  out  6  note for the voice strobed in voice_load
voice_active  out  NUM_NOTES  per-voice active flags
voice_sample_ready  in  NUM_NOTES  voice i has a new sample on its slice
voice_samples  in  NUM_NOTES*16  per-voice signed samples; slice i = [16i+15:16i]
samples_ready  out  1  1-cycle frame strobe to the mixer
samples  out  NUM_NOTES*16  frame to the mixer
multiplier  out  8  gain code to the mixer
active_count  out  4  number of active voices

Behaviour:
- Reset values: all outputs 0, all durations 0, collect mask 0. Reset mid-frame discards the partial frame.
- note_on_ready is registered: 1 when at least one voice was inactive at the start of the cycle (see VOICE_STEAL_EN).
- Accept = note_on_valid & note_on_ready.
  - duration 0: consumed, no allocation.
  - otherwise: lowest-index free voice i is loaded. Next cycle: voice_active[i]=1, duration[i]=note_duration, voice_load=1<<i for 1 cycle, voice_note=note_on.
- On beat, each active voice decrements its duration. A voice whose duration reaches 0 clears voice_active next cycle.
- Same-cycle accept and expiry: allocation uses pre-expiry state, so a freed slot is usable from the next cycle. A voice loaded in the cycle a beat arrives is not decremented.
- Frame collection:
  - On voice_sample_ready[i] & voice_active[i], latch slice i and set collect[i]. A repeat before emission overwrites; newest sample wins.
  - When active != 0 and (collect | ~active) is all ones, emit the frame the next cycle:
    - samples_ready=1 for 1 cycle.
    - samples = latched slices, with inactive slices forced to 0.
    - collect cleared.
  - If active == 0: sample_tick emits an all-zero frame the next cycle, with multiplier 0.
  - A voice that expires mid-frame drops out of the completion test immediately.
- samples, multiplier and active_count are updated only at frame emission and held stable between strobes.
  - multiplier = round(256*(k-1)/k), k = active voices in the frame.
  - k=0 or 1 -> 0; 2->128, 3->171, 4->192, 5->205, 6->213, 7->219, 8->224 (constant table).
- samples_ready never fires on two consecutive cycles; minimum frame spacing is 2 cycles.

Optional Feature:
VOICE_STEAL_EN
- Defined: note_on_ready is held at 1 (after reset). When all voices are active, a request steals the voice with the smallest remaining duration (lowest index on tie). That voice gets voice_load, its new note and its new duration, and its collect bit is cleared.
- Undefined: note_on_ready=0 while all voices are active, so requests stall until a voice expires.

Test Plan:
- Reset, then note_on=40, dur=3 -> voice_load=001, voice_note=40, voice_active=001. After 3 beats voice_active=000.
- Voices 0/1/2 active; voice_sample_ready pulses with 12000, 25000, -20536 (16'sd45000) in different cycles -> one samples_ready after the last, samples carries all three, multiplier=171, active_count=3.
- Two voices active, only voice 0 reports -> no strobe. Voice 1 expires on beat -> strobe with slice1=0, multiplier=0, active_count=1.
- No voices active, sample_tick -> samples_ready next cycle with samples=0 and multiplier=0.
- All 3 voices full, new request (durations 5, 2, 2), macro off -> note_on_ready=0 until an expiry. Macro on -> voice 1 stolen, voice_load=010.
- note_duration=0 request -> accepted, no voice_load, voice_active unchanged. Reset asserted mid-collection -> no samples_ready, all outputs 0.
